// File: rtl/sync_ram_alu.sv
// Synchronous-write RAM with combinational read on a shared data bus,
// plus an independent unsigned combinational ALU.
module sync_ram_alu #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int ALU_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ALU_WIDTH-1:0]  A,
    input  logic [ALU_WIDTH-1:0]  B,
    input  logic [3:0]            ALU_Sel,
    output logic [ALU_WIDTH-1:0]  ALU_Out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic                  rd_en;

    // Write wins over output enable, so the RAM never drives while writing.
    assign wr_en = cs_input && we && !rst;
    assign rd_en = cs_input && !we && oe && !rst;

    assign data = rd_en ? mem[addr] : {DATA_WIDTH{1'bz}};

    // Store the bus word; reset only blocks the write, contents are kept.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= data;
        end
    end

    // Unsigned ALU; results are truncated to ALU_WIDTH.
    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            4'b0000: ALU_Out = A;
            4'b0001: ALU_Out = A + B;
            4'b0010: ALU_Out = A - B;
            4'b0011: ALU_Out = A & B;
            4'b0100: ALU_Out = A | B;
            4'b0101: ALU_Out = ~A;
            4'b0110: ALU_Out = A ^ B;
            4'b0111: ALU_Out = A * B;
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: tb/tb_sync_ram_alu.sv
// Directed bench for sync_ram_alu: RAM write/read/float behaviour,
// reset write-blocking, address extremes and ALU operations.
module tb_sync_ram_alu;

    logic        clk;
    logic        rst;
    logic [11:0] addr;
    wire  [15:0] data;
    logic        cs_input;
    logic        we;
    logic        oe;
    logic [11:0] A;
    logic [11:0] B;
    logic [3:0]  ALU_Sel;
    logic [11:0] ALU_Out;

    logic [15:0] drv_val;
    logic        drv_en;

    int checks = 0;
    int errors = 0;

    assign data = drv_en ? drv_val : 16'hzzzz;

    sync_ram_alu dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data     (data),
        .cs_input (cs_input),
        .we       (we),
        .oe       (oe),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a write for one rising edge, then release the bus.
    task automatic ram_write(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        addr     = a;
        drv_val  = d;
        drv_en   = 1'b1;
        cs_input = 1'b1;
        we       = 1'b1;
        oe       = 1'b0;
        @(negedge clk);
        drv_en   = 1'b0;
        we       = 1'b0;
        cs_input = 1'b0;
    endtask

    // Combinational read: sample a little after presenting the address.
    task automatic ram_read(input logic [11:0] a, output logic [15:0] d);
        @(negedge clk);
        addr     = a;
        drv_en   = 1'b0;
        cs_input = 1'b1;
        we       = 1'b0;
        oe       = 1'b1;
        #1;
        d = data;
        @(negedge clk);
        cs_input = 1'b0;
        oe       = 1'b0;
    endtask

    // A floating bus reads as Z in 4-state simulators, 0 in 2-state ones.
    function automatic logic [15:0] is_idle(input logic [15:0] v);
        return {15'd0, (v === 16'hzzzz) || (v === 16'h0000)};
    endfunction

    task automatic alu(input string tag, input logic [11:0] a,
                       input logic [11:0] b, input logic [3:0] s,
                       input logic [11:0] exp);
        A       = a;
        B       = b;
        ALU_Sel = s;
        #1;
        check(tag, {4'd0, ALU_Out}, {4'd0, exp});
    endtask

    logic [15:0] rd;

    initial begin
        rst      = 1'b1;
        addr     = '0;
        drv_val  = '0;
        drv_en   = 1'b0;
        cs_input = 1'b0;
        we       = 1'b0;
        oe       = 1'b0;
        A        = '0;
        B        = '0;
        ALU_Sel  = '0;
        repeat (2) @(negedge clk);
        check("reset_bus_idle", is_idle(data), 16'd1);
        rst = 1'b0;

        ram_write(12'h100, 16'h1120);
        ram_write(12'h102, 16'h212A);
        ram_read(12'h100, rd);
        check("rd_100", rd, 16'h1120);
        ram_read(12'h102, rd);
        check("rd_102", rd, 16'h212A);

        // Same-address read right after a write.
        ram_write(12'h055, 16'h5A5A);
        ram_read(12'h055, rd);
        check("rd_after_wr", rd, 16'h5A5A);

        // Float cases at an address holding nonzero data.
        @(negedge clk);
        addr = 12'h100; cs_input = 1'b1; we = 1'b0; oe = 1'b0;
        #1 check("oe0_idle", is_idle(data), 16'd1);
        @(negedge clk);
        cs_input = 1'b0; oe = 1'b1;
        #1 check("cs0_idle", is_idle(data), 16'd1);
        @(negedge clk);
        cs_input = 1'b1; rst = 1'b1;
        #1 check("rst_idle", is_idle(data), 16'd1);
        @(negedge clk);
        rst = 1'b0; cs_input = 1'b0; oe = 1'b0;

        // we and oe together: write must land without contention.
        ram_write(12'h200, 16'hAAAA);
        @(negedge clk);
        addr = 12'h200; drv_val = 16'h5555; drv_en = 1'b1;
        cs_input = 1'b1; we = 1'b1; oe = 1'b1;
        #1 check("we_oe_bus", data, 16'h5555);
        @(negedge clk);
        drv_en = 1'b0; we = 1'b0; oe = 1'b0; cs_input = 1'b0;
        ram_read(12'h200, rd);
        check("we_oe_stored", rd, 16'h5555);

        // Reset blocks a write but keeps prior contents.
        ram_write(12'h12A, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        addr = 12'h12A; drv_val = 16'hBEEF; drv_en = 1'b1;
        cs_input = 1'b1; we = 1'b1;
        @(negedge clk);
        rst = 1'b0; drv_en = 1'b0; we = 1'b0; cs_input = 1'b0;
        ram_read(12'h12A, rd);
        check("rst_no_write", rd, 16'h0000);
        ram_read(12'h100, rd);
        check("rst_keeps_mem", rd, 16'h1120);
        ram_write(12'h12A, 16'hBEEF);
        ram_read(12'h12A, rd);
        check("post_rst_write", rd, 16'hBEEF);

        // Address extremes.
        ram_write(12'hFFF, 16'h0FFF);
        ram_write(12'h000, 16'h0001);
        ram_read(12'hFFF, rd);
        check("rd_fff", rd, 16'h0FFF);
        ram_read(12'h000, rd);
        check("rd_000", rd, 16'h0001);

        // ALU vectors.
        alu("add_wrap", 12'hFFF, 12'h001, 4'b0001, 12'h000);
        alu("sub",      12'hFFF, 12'h001, 4'b0010, 12'hFFE);
        alu("and",      12'hFFF, 12'h001, 4'b0011, 12'h001);
        alu("or",       12'hFFF, 12'h001, 4'b0100, 12'hFFF);
        alu("not",      12'hFFF, 12'h001, 4'b0101, 12'h000);
        alu("not_b_ign",12'h0F0, 12'hABC, 4'b0101, 12'hF0F);
        alu("xor",      12'h5A5, 12'h0FF, 4'b0110, 12'h55A);
        alu("mul",      12'h00A, 12'h00C, 4'b0111, 12'h078);
        alu("mul_trunc",12'h100, 12'h100, 4'b0111, 12'h000);
        alu("sel_1010", 12'h00A, 12'h00C, 4'b1010, 12'h000);
        alu("sel_1111", 12'h123, 12'h456, 4'b1111, 12'h000);
        alu("pass",     12'h3C7, 12'h001, 4'b0000, 12'h3C7);
        alu("sub_wrap", 12'h001, 12'h002, 4'b0010, 12'hFFF);
        rst = 1'b1;
        alu("alu_in_rst", 12'h00A, 12'h005, 4'b0001, 12'h00F);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_ram_alu.md
SYNC_RAM_ALU -- requirements
Module: sync_ram_alu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, giving the RAM address width; depth is 2^ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the RAM word width.
REQ-003 The block SHALL have parameter ALU_WIDTH, default 12, giving the ALU operand and result width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: rising-edge clock for all sequential logic.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port addr, input, ADDR_WIDTH: RAM word address.
REQ-008 Port data, inout, DATA_WIDTH: bidirectional RAM data bus.
REQ-009 Port cs_input, input, 1: RAM chip select, active high.
REQ-010 Port we, input, 1: RAM write enable, active high.
REQ-011 Port oe, input, 1: RAM output enable, active high.
REQ-012 Port A, input, ALU_WIDTH: ALU operand A.
REQ-013 Port B, input, ALU_WIDTH: ALU operand B.
REQ-014 Port ALU_Sel, input, 4: ALU operation select.
REQ-015 Port ALU_Out, output, ALU_WIDTH: ALU result.

Function -- RAM
REQ-016 The RAM SHALL write data into mem[addr] on a rising clk edge when cs_input=1, we=1 and rst=0.
REQ-017 The write SHALL not depend on oe.
REQ-018 The RAM SHALL drive data combinationally with mem[addr] when cs_input=1, we=0, oe=1 and rst=0.
REQ-019 When driven per REQ-018, data SHALL be valid in the same cycle addr is presented, so it can be sampled at the next rising edge.
REQ-020 In every other case the RAM SHALL leave data high-Z, including when we=1 and oe=1 are both asserted (write has priority, no bus contention).
REQ-021 The full address range 0..2^ADDR_WIDTH-1 SHALL be addressable, with no wrap or aliasing.
REQ-022 A write followed by a read of the same address on the next cycle SHALL return the newly written word.
REQ-023 Memory content SHALL be undefined (X) until written.

Function -- ALU
REQ-024 The ALU SHALL be purely combinational; ALU_Out SHALL be a function of A, B and ALU_Sel only.
REQ-025 ALU_Sel=0001 SHALL give ALU_Out = A+B, truncated to ALU_WIDTH (carry discarded, wraps).
REQ-026 ALU_Sel=0010 SHALL give ALU_Out = A-B, modulo 2^ALU_WIDTH.
REQ-027 ALU_Sel=0011 SHALL give ALU_Out = A AND B.
REQ-028 ALU_Sel=0100 SHALL give ALU_Out = A OR B.
REQ-029 ALU_Sel=0101 SHALL give ALU_Out = NOT A (B ignored).
REQ-030 ALU_Sel=0110 SHALL give ALU_Out = A XOR B.
REQ-031 ALU_Sel=0111 SHALL give ALU_Out = low ALU_WIDTH bits of A*B (unsigned).
REQ-032 ALU_Sel=0000 SHALL give ALU_Out = A (pass-through).
REQ-033 ALU_Sel=1000..1111 SHALL give ALU_Out = 0.
REQ-034 All ALU operands SHALL be treated as unsigned.

Reset
REQ-035 While rst=1 at a rising edge, no RAM write SHALL occur.
REQ-036 While rst=1, data SHALL be high-Z.
REQ-037 Reset SHALL not alter memory contents.
REQ-038 Reset SHALL not affect the ALU; ALU_Out remains combinational.
REQ-039 Deasserting rst SHALL restore normal operation from the next rising edge.

Verification
REQ-040 Write 0x1120 to addr 0x100 and 0x212A to addr 0x102; read both back with cs=1, we=0, oe=1 -> data = 0x1120, then 0x212A.
REQ-041 With we=0, oe=0 or with cs_input=0 -> data is high-Z; with we=1, oe=1 -> word written and data not driven by the RAM.
REQ-042 ALU with A=0xFFF, B=0x001: Sel 0001 -> 0x000; Sel 0010 -> 0xFFE; Sel 0011 -> 0x001; Sel 0100 -> 0xFFF; Sel 0101 -> 0x000.
REQ-043 ALU with A=0x00A, B=0x00C: Sel 0111 -> 0x078; A=0x100, B=0x100, Sel 0111 -> 0x000 (truncation); Sel 1010 -> 0x000.
REQ-044 Assert rst while we=1 to addr 0x12A carrying 0xBEEF -> mem[0x12A] keeps its prior value 0x0000; after rst=0 the same write stores 0xBEEF.
REQ-045 Write 0x0FFF to addr 0xFFF and 0x0001 to addr 0x000 -> both read back intact (no aliasing at the address extremes).
